// File: rtl/dptr_multiciclo.sv
// rtl/dptr_multiciclo.sv - multi-cycle MIPS-subset datapath (R-type, LW, SW); optional overflow trap via DPTR_OVF_EN
module dptr_multiciclo #(
   parameter int DATA_W    = 32,
   parameter int RA_W      = 5,
   parameter int MEM_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic              dbg_we,
   input  logic [RA_W-1:0]   dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result,
   output logic              zf
);

   localparam int MA_W = $clog2(MEM_DEPTH);
   localparam int NREG = 2 ** RA_W;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_DONE_ERR
   } state_t;

   state_t state, state_nx;

   logic [31:0]       ir;
   logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q, result_q;
   logic              zf_q;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] mem  [MEM_DEPTH];

   logic [DATA_W-1:0] alu;
   logic [DATA_W-1:0] imm_ext;
   logic              funct_ok;
   logic [5:0]        op, fn;
   logic [RA_W-1:0]   rs_a, rt_a, rd_a;
   logic              is_rtype, is_lw, is_sw, is_mem;
   logic [MA_W-1:0]   maddr;
   logic              unused_bits;

`ifdef DPTR_OVF_EN
   logic ovf, ovf_q;
`endif

   assign op       = ir[31:26];
   assign fn       = ir[5:0];
   assign rs_a     = RA_W'(ir[25:21]);
   assign rt_a     = RA_W'(ir[20:16]);
   assign rd_a     = RA_W'(ir[15:11]);
   assign is_rtype = (op == OP_RTYPE);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_mem   = is_lw | is_sw;
   assign imm_ext  = {{(DATA_W-16){ir[15]}}, ir[15:0]};
   // Word address wraps: only the bits that index the memory are kept
   assign maddr    = alu_q[MA_W+1:2];
   assign zf       = zf_q;
   assign unused_bits = ^{ir[10:6], alu_q[DATA_W-1:MA_W+2], alu_q[1:0]};

   // ALU and ALU control: address add for memory ops, funct-selected op for R-type
   always_comb begin
      alu      = '0;
      funct_ok = 1'b1;
      if (is_mem) begin
         alu = a_q + imm_ext;
      end else begin
         case (fn)
            FN_ADD:  alu = a_q + b_q;
            FN_SUB:  alu = a_q - b_q;
            FN_AND:  alu = a_q & b_q;
            FN_OR:   alu = a_q | b_q;
            FN_NOR:  alu = ~(a_q | b_q);
            FN_SLT:  alu = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: funct_ok = 1'b0;
         endcase
      end
   end

`ifdef DPTR_OVF_EN
   // Signed overflow of R-type add/sub; address arithmetic is never trapped
   always_comb begin
      ovf = 1'b0;
      if (is_rtype && fn == FN_ADD)
         ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu[DATA_W-1] != a_q[DATA_W-1]);
      else if (is_rtype && fn == FN_SUB)
         ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu[DATA_W-1] != a_q[DATA_W-1]);
   end
`endif

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // FSM next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:     if (instr_valid) state_nx = S_DECODE;
         S_DECODE:   state_nx = (is_rtype || is_mem) ? S_EXEC : S_DONE_ERR;
         S_EXEC:     if (is_mem)        state_nx = S_MEM;
                     else if (funct_ok) state_nx = S_WB;
                     else               state_nx = S_DONE_ERR;
         S_MEM:      state_nx = is_lw ? S_WB : S_IDLE;
         S_WB:       state_nx = S_IDLE;
         S_DONE_ERR: state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // FSM outputs; result shows the retiring value in the done cycle and holds otherwise
   always_comb begin
      instr_ready = (state == S_IDLE);
      busy        = (state != S_IDLE);
      done        = 1'b0;
      err         = 1'b0;
      result      = result_q;
      case (state)
         S_MEM: if (is_sw) begin
            done   = 1'b1;
            result = alu_q;
         end
         S_WB: begin
            done   = 1'b1;
            result = is_lw ? mdr_q : alu_q;
`ifdef DPTR_OVF_EN
            err    = ovf_q;
`endif
         end
         S_DONE_ERR: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers and register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir       <= '0;
         a_q      <= '0;
         b_q      <= '0;
         alu_q    <= '0;
         mdr_q    <= '0;
         zf_q     <= 1'b0;
         result_q <= '0;
`ifdef DPTR_OVF_EN
         ovf_q    <= 1'b0;
`endif
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         result_q <= result;
         case (state)
            S_IDLE: begin
               if (dbg_we && dbg_addr != '0) regs[dbg_addr] <= dbg_data;
               if (instr_valid) ir <= instr;
            end
            S_DECODE: begin
               a_q <= (rs_a == '0) ? '0 : regs[rs_a];
               b_q <= (rt_a == '0) ? '0 : regs[rt_a];
            end
            S_EXEC: begin
               alu_q <= alu;
               if (is_mem || funct_ok) zf_q <= (alu == '0);
`ifdef DPTR_OVF_EN
               ovf_q <= ovf;
`endif
            end
            S_MEM: mdr_q <= mem[maddr];
            S_WB: begin
               if (is_lw) begin
                  if (rt_a != '0) regs[rt_a] <= mdr_q;
               end else begin
`ifdef DPTR_OVF_EN
                  if (rd_a != '0 && !ovf_q) regs[rd_a] <= alu_q;
`else
                  if (rd_a != '0) regs[rd_a] <= alu_q;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // Data memory write port; reset forces IDLE so an aborted store never lands
   always_ff @(posedge clk) begin
      if (state == S_MEM && is_sw) mem[maddr] <= b_q;
   end

endmodule

// File: tb/tb_dptr_multiciclo.sv
// tb/tb_dptr_multiciclo.sv - randomized model-checked bench for dptr_multiciclo
module tb_dptr_multiciclo;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        dbg_we;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        busy, done, err, zf;
   logic [31:0] result;

   int cmp_cnt = 0;
   int err_cnt = 0;

   logic [31:0] mreg [32];
   logic [31:0] mmem [64];
   logic [31:0] mres;
   logic        mzf;

   dptr_multiciclo #(.DATA_W(32), .RA_W(5), .MEM_DEPTH(64)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_data(dbg_data), .busy(busy), .done(done), .err(err),
      .result(result), .zf(zf)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic bit legal_fn(input logic [5:0] fn);
      return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h27 || fn == 6'h2A;
   endfunction

   // Architectural model of one instruction
   task automatic model_exec(input logic [31:0] ins, output logic [31:0] e_res,
                             output logic e_err, output logic e_zf, output int e_lat);
      logic [5:0]  op, fn;
      int          rs, rt, rd, idx;
      logic [31:0] a, b, r, addr;
      longint      s;
      bit          ovf;
      op = ins[31:26]; fn = ins[5:0];
      rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      a = mreg[rs]; b = mreg[rt];
      e_err = 1'b0; r = '0; s = 0;
      if (op == 6'h00) begin
         e_lat = 3;
         if (!legal_fn(fn)) begin
            e_err = 1'b1;
         end else begin
            case (fn)
               6'h20: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); end
               6'h22: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); end
               6'h24: r = a & b;
               6'h25: r = a | b;
               6'h27: r = ~(a | b);
               default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
            ovf = (fn == 6'h20 || fn == 6'h22) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            mzf = (r == 0);
            mres = r;
`ifdef DPTR_OVF_EN
            if (ovf) e_err = 1'b1;
            else if (rd != 0) mreg[rd] = r;
`else
            if (rd != 0) mreg[rd] = r;
`endif
         end
      end else if (op == 6'h23 || op == 6'h2B) begin
         addr = a + {{16{ins[15]}}, ins[15:0]};
         mzf = (addr == 0);
         idx = int'((addr / 4) % 64);
         if (op == 6'h23) begin
            e_lat = 4;
            mres = mmem[idx];
            if (rt != 0) mreg[rt] = mmem[idx];
         end else begin
            e_lat = 3;
            mmem[idx] = b;
            mres = addr;
         end
      end else begin
         e_lat = 2;
         e_err = 1'b1;
      end
      e_res = mres;
      e_zf  = mzf;
   endtask

   task automatic dbg_write(input int a, input logic [31:0] d);
      dbg_we = 1'b1; dbg_addr = 5'(a); dbg_data = d;
      @(posedge clk);
      @(negedge clk);
      dbg_we = 1'b0;
      if (a != 0) mreg[a] = d;
   endtask

   // Issue one instruction, compare every observable output against the model
   task automatic exec_chk(input logic [31:0] ins, input bit noise, input bit dwe,
                           input int da, input logic [31:0] dd,
                           output logic [31:0] o_res, output logic o_err,
                           output logic o_zf, output int o_lat);
      logic [31:0] e_res;
      logic        e_err, e_zf;
      int          e_lat;
      if (dwe && da != 0) mreg[da] = dd;
      model_exec(ins, e_res, e_err, e_zf, e_lat);
      instr = ins; instr_valid = 1'b1;
      dbg_we = dwe; dbg_addr = 5'(da); dbg_data = dd;
      chk("ready_before_accept", {31'b0, instr_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0; dbg_we = 1'b0;
      o_lat = 1;
      while (done !== 1'b1 && o_lat < 8) begin
         chk("busy_handshake", {30'b0, busy, instr_ready}, 32'd2);
         if (noise) begin
            instr_valid = 1'($urandom % 2); instr = $urandom;
            dbg_we = 1'($urandom % 2); dbg_addr = 5'($urandom); dbg_data = $urandom;
         end
         @(negedge clk);
         o_lat++;
      end
      instr_valid = 1'b0; dbg_we = 1'b0;
      o_res = result; o_err = err; o_zf = zf;
      chk("latency", 32'(o_lat), 32'(e_lat));
      chk("result", o_res, e_res);
      chk("err", {31'b0, o_err}, {31'b0, e_err});
      chk("zf", {31'b0, o_zf}, {31'b0, e_zf});
      chk("busy_at_done", {31'b0, busy}, 32'd1);
      @(negedge clk);
      chk("idle_after_done", {29'b0, busy, instr_ready, done}, 32'd2);
   endtask

   task automatic run(input logic [31:0] ins, output logic [31:0] o_res,
                      output logic o_err, output logic o_zf, output int o_lat);
      exec_chk(ins, 1'b0, 1'b0, 0, 32'h0, o_res, o_err, o_zf, o_lat);
   endtask

   task automatic read_reg(input int x, output logic [31:0] v);
      logic e, z;
      int   l;
      run(enc_r(x, 0, x, 6'h25), v, e, z, l);
   endtask

   initial begin
      logic [31:0] r, v;
      logic        e, z;
      int          l;

      rst = 1'b1; instr = '0; instr_valid = 1'b0;
      dbg_we = 1'b0; dbg_addr = '0; dbg_data = '0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      mres = '0; mzf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_state", {26'b0, instr_ready, busy, done, err, zf, 1'b0}, 32'h20);
      chk("reset_result", result, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Fill the whole data memory so every later load is predictable
      for (int i = 0; i < 64; i++) begin
         dbg_write(1, 32'(i * 4));
         dbg_write(2, $urandom);
         run(enc_i(6'h2B, 1, 2, 16'h0), r, e, z, l);
      end

      // add / or readback
      dbg_write(1, 32'd5); dbg_write(2, 32'd7);
      run(32'h00221820, r, e, z, l);
      chk("add_lat", 32'(l), 32'd3);
      chk("add_res", r, 32'd12);
      chk("add_zf", {31'b0, z}, 32'd0);
      run(enc_r(3, 0, 4, 6'h25), r, e, z, l);
      chk("or_r4_res", r, 32'd12);

      // sub to zero, slt
      dbg_write(1, 32'd7); dbg_write(2, 32'd7);
      run(enc_r(1, 2, 5, 6'h22), r, e, z, l);
      chk("sub_res", r, 32'd0);
      chk("sub_zf", {31'b0, z}, 32'd1);
      read_reg(5, v);
      chk("r5_zero", v, 32'd0);
      run(enc_r(0, 1, 6, 6'h2A), r, e, z, l);
      chk("slt_res", r, 32'd1);
      read_reg(6, v);
      chk("r6_one", v, 32'd1);

      // store then load
      dbg_write(1, 32'h10); dbg_write(2, 32'hDEADBEEF);
      run(enc_i(6'h2B, 1, 2, 16'd4), r, e, z, l);
      chk("sw_lat", 32'(l), 32'd3);
      chk("sw_res", r, 32'h14);
      run(enc_i(6'h23, 1, 7, 16'd4), r, e, z, l);
      chk("lw_lat", 32'(l), 32'd4);
      chk("lw_res", r, 32'hDEADBEEF);
      read_reg(7, v);
      chk("r7_loaded", v, 32'hDEADBEEF);

      // illegal opcode and illegal funct
      run({6'h3F, 26'h0221820}, r, e, z, l);
      chk("bad_op_lat", 32'(l), 32'd2);
      chk("bad_op_err", {31'b0, e}, 32'd1);
      run(enc_r(1, 2, 3, 6'h3F), r, e, z, l);
      chk("bad_fn_lat", 32'(l), 32'd3);
      chk("bad_fn_err", {31'b0, e}, 32'd1);
      read_reg(3, v);
      chk("r3_kept", v, 32'd12);
      run(enc_r(1, 2, 0, 6'h20), r, e, z, l);
      dbg_write(0, 32'hFFFF_FFFF);
      read_reg(0, v);
      chk("r0_zero", v, 32'd0);

      // overflow behaviour
      dbg_write(1, 32'h7FFFFFFF); dbg_write(2, 32'd1); dbg_write(3, 32'h55);
      run(enc_r(1, 2, 3, 6'h20), r, e, z, l);
      chk("ovf_res", r, 32'h80000000);
      read_reg(3, v);
`ifdef DPTR_OVF_EN
      chk("ovf_err", {31'b0, e}, 32'd1);
      chk("ovf_r3", v, 32'h55);
`else
      chk("ovf_err", {31'b0, e}, 32'd0);
      chk("ovf_r3", v, 32'h80000000);
`endif

      // reset while a store sits in MEM
      dbg_write(1, 32'h20); dbg_write(2, 32'h12345678);
      instr = enc_i(6'h2B, 1, 2, 16'd4); instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sw_in_mem_done", {31'b0, done}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_state", {27'b0, instr_ready, busy, done, err, zf}, 32'h10);
      chk("rst_async_result", result, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      mres = '0; mzf = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         read_reg(i, v);
         chk("reg_cleared", v, 32'h0);
      end
      run(enc_i(6'h23, 0, 9, 16'h24), r, e, z, l);

      // randomized traffic with bus noise while busy
      for (int n = 0; n < 300; n++) begin
         int          k, rs, rt, rd;
         logic [5:0]  op, fn;
         logic [31:0] ins;
         if ($urandom % 4 == 0)
            dbg_write(int'($urandom % 32), ($urandom % 4 == 0) ? 32'($urandom % 3) : $urandom);
         k = int'($urandom % 10);
         rs = int'($urandom % 32); rt = int'($urandom % 32); rd = int'($urandom % 32);
         case (k)
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h27;
            5: fn = 6'h2A;
            default: begin
               fn = 6'($urandom);
               while (legal_fn(fn)) fn = 6'($urandom);
            end
         endcase
         if (k <= 5 || k == 9) begin
            ins = {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'($urandom), fn};
         end else if (k == 6 || k == 7) begin
            ins = enc_i((k == 6) ? 6'h23 : 6'h2B, rs, rt, 16'($urandom));
         end else begin
            op = 6'($urandom);
            while (op == 6'h00 || op == 6'h23 || op == 6'h2B) op = 6'($urandom);
            ins = {op, 26'($urandom)};
         end
         exec_chk(ins, 1'($urandom % 2), ($urandom % 4 == 0), int'($urandom % 32), $urandom,
                  r, e, z, l);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
